// File: rtl/gemm_tile_engine_if.sv
// Control, size and SRAM port bundle of the GEMM tile engine.
// The slave modport is the engine's view; master is the controller/memory side.
interface gemm_tile_engine_if #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int NumPE_M       = 4,
  parameter int NumPE_N       = 4,
  parameter int NumIp_K       = 4
);
  logic                                     start_i;
  logic                                     stall_i;
  logic [SizeAddrWidth-1:0]                 M_size_i;
  logic [SizeAddrWidth-1:0]                 K_size_i;
  logic [SizeAddrWidth-1:0]                 N_size_i;
  logic [AddrWidth-1:0]                     sram_a_addr_o;
  logic [AddrWidth-1:0]                     sram_b_addr_o;
  logic [NumPE_M*NumIp_K*InDataWidth-1:0]   sram_a_rdata_i;
  logic [NumPE_N*NumIp_K*InDataWidth-1:0]   sram_b_rdata_i;
  logic [AddrWidth-1:0]                     sram_c_addr_o;
  logic [NumPE_M*NumPE_N*OutDataWidth-1:0]  sram_c_wdata_o;
  logic                                     sram_c_we_o;
  logic                                     busy_o;
  logic                                     done_o;
  logic                                     err_o;

  modport slave (
    input  start_i, stall_i, M_size_i, K_size_i, N_size_i,
    input  sram_a_rdata_i, sram_b_rdata_i,
    output sram_a_addr_o, sram_b_addr_o,
    output sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
    output busy_o, done_o, err_o
  );

  modport master (
    output start_i, stall_i, M_size_i, K_size_i, N_size_i,
    output sram_a_rdata_i, sram_b_rdata_i,
    input  sram_a_addr_o, sram_b_addr_o,
    input  sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/gemm_tile_engine.sv
// Tiled GEMM engine: walks (m, n, k) tiles, reads A/B words, accumulates
// a NumPE_M x NumPE_N output tile and writes it to the C SRAM.
//
//   state | meaning
//   IDLE  | waiting for start_i; sizes checked and tile counts latched
//   RUN   | one A/B read address issued per unstalled cycle
//   DRAIN | all reads issued; waiting for the final C write
//   DONE  | done_o pulse, then back to IDLE
module gemm_tile_engine #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int NumPE_M       = 4,
  parameter int NumPE_N       = 4,
  parameter int NumIp_K       = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  gemm_tile_engine_if.slave bus
);
  localparam int NumOut = NumPE_M * NumPE_N;
  localparam int SW     = SizeAddrWidth;
  localparam int LW     = 2 * SizeAddrWidth;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                          state_q;
  logic [SW-1:0]                   mt_q, kt_q, nt_q, m_q, n_q, k_q;
  logic                            busy_q, done_q, err_q, we_q;
  logic                            v1_q, kfirst_q, klast_q;
  logic [AddrWidth-1:0]            c_addr1_q, c_addr_q;
  logic [NumOut*OutDataWidth-1:0]  wdata_q;
  logic signed [OutDataWidth-1:0]  acc_q [NumOut];
  logic signed [OutDataWidth-1:0]  acc_d [NumOut];
  logic signed [OutDataWidth-1:0]  sum_d;
  logic signed [2*InDataWidth-1:0] prod_d;
  logic signed [InDataWidth-1:0]   a_e, b_e;
  logic                            size_ok, k_last, n_last, m_last;
  logic [LW-1:0]                   a_lin, b_lin, c_lin;

  // Size legality, last-index flags and linear addresses of the current tile step
  always_comb begin
    size_ok = (bus.M_size_i != '0) && ((bus.M_size_i % SW'(NumPE_M)) == '0) &&
              (bus.K_size_i != '0) && ((bus.K_size_i % SW'(NumIp_K)) == '0) &&
              (bus.N_size_i != '0) && ((bus.N_size_i % SW'(NumPE_N)) == '0);
    k_last  = (k_q == kt_q - SW'(1));
    n_last  = (n_q == nt_q - SW'(1));
    m_last  = (m_q == mt_q - SW'(1));
    a_lin   = LW'(m_q) * LW'(kt_q) + LW'(k_q);
    b_lin   = LW'(n_q) * LW'(kt_q) + LW'(k_q);
    c_lin   = LW'(m_q) * LW'(nt_q) + LW'(n_q);
  end

  // Sequencer: start acceptance (even under stall), tile walk and completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mt_q    <= '0;
      kt_q    <= '0;
      nt_q    <= '0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start_i) begin
        err_q <= !size_ok;
        mt_q  <= bus.M_size_i / SW'(NumPE_M);
        kt_q  <= bus.K_size_i / SW'(NumIp_K);
        nt_q  <= bus.N_size_i / SW'(NumPE_N);
        if (size_ok) begin
          busy_q  <= 1'b1;
          state_q <= RUN;
        end else begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
      end
    end else if (!bus.stall_i) begin
      unique case (state_q)
        RUN: begin
          if (!k_last) begin
            k_q <= k_q + 1'b1;
          end else begin
            k_q <= '0;
            if (!n_last) begin
              n_q <= n_q + 1'b1;
            end else begin
              n_q <= '0;
              if (!m_last) begin
                m_q <= m_q + 1'b1;
              end else begin
                m_q     <= '0;
                state_q <= DRAIN;
              end
            end
          end
        end
        // The last read's data has been consumed once v1_q is clear
        DRAIN: begin
          if (we_q && !v1_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // PE array: per-PE dot product over the K lanes, then overwrite or accumulate
  always_comb begin
    acc_d  = '{default: '0};
    sum_d  = '0;
    prod_d = '0;
    a_e    = '0;
    b_e    = '0;
    for (int r = 0; r < NumPE_M; r++) begin
      for (int c = 0; c < NumPE_N; c++) begin
        sum_d = '0;
        for (int k = 0; k < NumIp_K; k++) begin
          a_e    = bus.sram_a_rdata_i[(r*NumIp_K+k)*InDataWidth +: InDataWidth];
          b_e    = bus.sram_b_rdata_i[(c*NumIp_K+k)*InDataWidth +: InDataWidth];
          prod_d = a_e * b_e;
          sum_d  = sum_d + OutDataWidth'(prod_d);
        end
        acc_d[r*NumPE_N+c] = kfirst_q ? sum_d : acc_q[r*NumPE_N+c] + sum_d;
      end
    end
  end

  // Read-return pipeline, accumulators and the C write register (separate from
  // the accumulators so the next tile's k=0 step can overlap the write)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      kfirst_q  <= 1'b0;
      klast_q   <= 1'b0;
      c_addr1_q <= '0;
      c_addr_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      for (int i = 0; i < NumOut; i++) acc_q[i] <= '0;
    end else if (!bus.stall_i) begin
      v1_q      <= (state_q == RUN);
      kfirst_q  <= (k_q == '0);
      klast_q   <= k_last;
      c_addr1_q <= AddrWidth'(c_lin);
      we_q      <= v1_q && klast_q;
      if (v1_q) begin
        for (int i = 0; i < NumOut; i++) acc_q[i] <= acc_d[i];
        if (klast_q) begin
          c_addr_q <= c_addr1_q;
          for (int i = 0; i < NumOut; i++) wdata_q[i*OutDataWidth +: OutDataWidth] <= acc_d[i];
        end
      end
    end
  end

  // A pending write or done pulse is held, not lost, while stalled
  assign bus.sram_a_addr_o  = AddrWidth'(a_lin);
  assign bus.sram_b_addr_o  = AddrWidth'(b_lin);
  assign bus.sram_c_addr_o  = c_addr_q;
  assign bus.sram_c_wdata_o = wdata_q;
  assign bus.sram_c_we_o    = we_q & ~bus.stall_i;
  assign bus.done_o         = done_q & ~bus.stall_i;
  assign bus.busy_o         = busy_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_gemm_tile_engine.sv
// Self-checking bench for gemm_tile_engine: SRAM model, write monitor and a
// matrix-level reference model.
module tb_gemm_tile_engine;
  localparam int IW = 8, OW = 32, AW = 16, SW = 8, PM = 4, PN = 4, PK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gemm_tile_engine_if #(.InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
    .SizeAddrWidth(SW), .NumPE_M(PM), .NumPE_N(PN), .NumIp_K(PK)) bus ();

  gemm_tile_engine #(.InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
    .SizeAddrWidth(SW), .NumPE_M(PM), .NumPE_N(PN), .NumIp_K(PK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int A_mat [16][16];
  int B_mat [16][16];
  logic [PM*PK*IW-1:0] a_mem [64];
  logic [PN*PK*IW-1:0] b_mem [64];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [AW-1:0]       wr_addr_q [$];
  logic [PM*PN*OW-1:0] wr_data_q [$];
  int                  wr_cyc_q  [$];
  logic [2*AW-1:0]     iss_q     [$];
  int busy_cnt = 0, done_cnt = 0, done_cyc = 0, stall_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read SRAM: data one cycle after the address, held under stall
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sram_a_rdata_i <= '0;
      bus.sram_b_rdata_i <= '0;
    end else if (!bus.stall_i) begin
      bus.sram_a_rdata_i <= a_mem[bus.sram_a_addr_o[5:0]];
      bus.sram_b_rdata_i <= b_mem[bus.sram_b_addr_o[5:0]];
    end
  end

  // Observe outputs mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_c_we_o) begin
        wr_addr_q.push_back(bus.sram_c_addr_o);
        wr_data_q.push_back(bus.sram_c_wdata_o);
        wr_cyc_q.push_back(cyc);
        if (bus.stall_i) stall_wr++;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy_o && !bus.stall_i) begin
        busy_cnt++;
        iss_q.push_back({bus.sram_a_addr_o, bus.sram_b_addr_o});
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0: random int8, 1: A=1 B=2, 2: A=B=-128
  task automatic fill(input int mode);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        case (mode)
          1:       begin A_mat[i][j] = 1;    B_mat[i][j] = 2;    end
          2:       begin A_mat[i][j] = -128; B_mat[i][j] = -128; end
          default: begin
            A_mat[i][j] = int'($urandom_range(0, 255)) - 128;
            B_mat[i][j] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
  endtask

  // A word (m,k) holds rows m*PM.., cols k*PK..; B word (n,k) holds B[k*PK..][n*PN..]
  task automatic load_mem(input int M, input int K, input int N);
    int kt;
    kt = K / PK;
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    for (int m = 0; m < M / PM; m++)
      for (int k = 0; k < kt; k++)
        for (int r = 0; r < PM; r++)
          for (int l = 0; l < PK; l++)
            a_mem[m*kt+k][(r*PK+l)*IW +: IW] = 8'(A_mat[m*PM+r][k*PK+l]);
    for (int n = 0; n < N / PN; n++)
      for (int k = 0; k < kt; k++)
        for (int c = 0; c < PN; c++)
          for (int l = 0; l < PK; l++)
            b_mem[n*kt+k][(c*PK+l)*IW +: IW] = 8'(B_mat[k*PK+l][n*PN+c]);
  endtask

  function automatic logic [31:0] gold(input int row, input int col, input int K);
    int s;
    s = 0;
    for (int k = 0; k < K; k++) s += A_mat[row][k] * B_mat[k][col];
    return 32'(s);
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    iss_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    stall_wr = 0;
  endtask

  // smode 0: no stall, 1: 3-cycle burst at burst_at, 2: random stalls
  task automatic run_job(input int M, input int K, input int N, input int smode,
                         input int burst_at, input string tag);
    int mt, kt, nt, st_cyc, j;
    logic bad;
    logic [PM*PN*OW-1:0] wd;
    bad = (M == 0) || (K == 0) || (N == 0) || (M % PM != 0) || (K % PK != 0) || (N % PN != 0);
    mt = M / PM; kt = K / PK; nt = N / PN;
    if (!bad) load_mem(M, K, N);
    clear_obs();
    @(posedge clk); #2;
    bus.M_size_i = 8'(M);
    bus.K_size_i = 8'(K);
    bus.N_size_i = 8'(N);
    bus.start_i  = 1'b1;
    bus.stall_i  = (smode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    st_cyc = cyc + 1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != 0) break;
      case (smode)
        1:       bus.stall_i = (i >= burst_at) && (i < burst_at + 3);
        2:       bus.stall_i = ($urandom_range(0, 3) == 0);
        default: bus.stall_i = 1'b0;
      endcase
      @(posedge clk); #2;
    end
    bus.stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    check({tag, ".err"}, 64'(bus.err_o), 64'(bad));
    check({tag, ".write_during_stall"}, 64'(stall_wr), 64'd0);
    if (bad) begin
      check({tag, ".writes"}, 64'(wr_addr_q.size()), 64'd0);
      check({tag, ".done_latency_le3"}, 64'((done_cyc - st_cyc + 1) <= 3), 64'd1);
    end else begin
      check({tag, ".writes"}, 64'(wr_addr_q.size()), 64'(mt*nt));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(mt*nt*kt + 2));
      j = 0;
      for (int m = 0; m < mt; m++)
        for (int n = 0; n < nt; n++)
          for (int k = 0; k < kt; k++) begin
            check($sformatf("%s.issue%0d", tag, j),
                  64'((j < iss_q.size()) ? iss_q[j] : 32'hffff_ffff),
                  64'({AW'(m*kt+k), AW'(n*kt+k)}));
            j++;
          end
      for (int w = 0; w < wr_addr_q.size() && w < mt*nt; w++) begin
        wd = wr_data_q[w];
        check($sformatf("%s.wr%0d.addr", tag, w), 64'(wr_addr_q[w]), 64'(w));
        for (int r = 0; r < PM; r++)
          for (int c = 0; c < PN; c++)
            check($sformatf("%s.wr%0d.c%0d_%0d", tag, w, r, c), 64'(wd[(r*PN+c)*OW +: OW]),
                  64'(gold((w / nt)*PM + r, (w % nt)*PN + c, K)));
      end
      if (smode == 0 && wr_cyc_q.size() > 0)
        check({tag, ".done_after_last_write"}, 64'(done_cyc), 64'(wr_cyc_q[$] + 1));
    end
  endtask

  initial begin
    int sizes [4];
    sizes = '{4, 8, 12, 16};
    bus.start_i  = 1'b0;
    bus.stall_i  = 1'b0;
    bus.M_size_i = '0;
    bus.K_size_i = '0;
    bus.N_size_i = '0;
    #1 rst_n = 1'b0;
    #20;
    check("reset.busy",  64'(bus.busy_o), 64'd0);
    check("reset.done",  64'(bus.done_o), 64'd0);
    check("reset.err",   64'(bus.err_o), 64'd0);
    check("reset.we",    64'(bus.sram_c_we_o), 64'd0);
    check("reset.aaddr", 64'(bus.sram_a_addr_o), 64'd0);
    check("reset.caddr", 64'(bus.sram_c_addr_o), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("idle.no_busy_without_start", 64'(bus.busy_o), 64'd0);

    fill(1);
    run_job(4, 4, 4, 0, 0, "single");
    fill(0);
    run_job(8, 8, 8, 0, 0, "multi");
    run_job(8, 8, 8, 1, 1, "stall");
    fill(2);
    run_job(4, 8, 4, 0, 0, "extreme");
    run_job(6, 8, 8, 0, 0, "bad_m");
    fill(0);
    run_job(8, 4, 4, 0, 0, "after_bad");

    // Reset in the middle of RUN
    load_mem(8, 8, 8);
    clear_obs();
    @(posedge clk); #2;
    bus.M_size_i = 8'd8;
    bus.K_size_i = 8'd8;
    bus.N_size_i = 8'd8;
    bus.start_i  = 1'b1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midrst.busy_before", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy",  64'(bus.busy_o), 64'd0);
    check("midrst.done",  64'(bus.done_o), 64'd0);
    check("midrst.we",    64'(bus.sram_c_we_o), 64'd0);
    check("midrst.aaddr", 64'(bus.sram_a_addr_o), 64'd0);
    check("midrst.baddr", 64'(bus.sram_b_addr_o), 64'd0);
    check("midrst.caddr", 64'(bus.sram_c_addr_o), 64'd0);
    check("midrst.wdata_zero", 64'(bus.sram_c_wdata_o == '0), 64'd1);
    clear_obs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("midrst.writes_after", 64'(wr_addr_q.size()), 64'd0);
    check("midrst.done_after", 64'(done_cnt), 64'd0);
    check("midrst.busy_after", 64'(bus.busy_o), 64'd0);
    run_job(8, 8, 8, 0, 0, "post_reset");

    for (int t = 0; t < 4; t++) begin
      fill(0);
      run_job(sizes[$urandom_range(0, 3)], sizes[$urandom_range(0, 3)],
              sizes[$urandom_range(0, 3)], 2, 0, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gemm_tile_engine.md
GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

Interface
REQ-001 SHALL have parameter InDataWidth, default 8: signed element width of A and B.
REQ-002 SHALL have parameter OutDataWidth, default 32: signed accumulator and C element width.
REQ-003 SHALL have parameter AddrWidth, default 16: SRAM word-address width.
REQ-004 SHALL have parameter SizeAddrWidth, default 8: width of the M, K and N size inputs.
REQ-005 SHALL have parameters NumPE_M, NumPE_N and NumIp_K, each default 4: PE rows, PE columns and K-lanes per PE.
REQ-006 SHALL have clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have start_i, input, 1 bit: job start, sampled only in IDLE.
REQ-009 SHALL have stall_i, input, 1 bit: global hold; freezes all state while high.
REQ-010 SHALL have M_size_i, K_size_i and N_size_i, inputs, SizeAddrWidth bits each: matrix sizes in elements, sampled at start.
REQ-011 SHALL have sram_a_addr_o and sram_b_addr_o, outputs, AddrWidth bits each: A and B read word addresses.
REQ-012 SHALL have sram_a_rdata_i, input, NumPE_M*NumIp_K*InDataWidth bits: A read data; lane (r,k) occupies bits [(r*NumIp_K+k)*InDataWidth +: InDataWidth].
REQ-013 SHALL have sram_b_rdata_i, input, NumPE_N*NumIp_K*InDataWidth bits: B read data; lane (c,k) occupies bits [(c*NumIp_K+k)*InDataWidth +: InDataWidth].
REQ-014 SHALL have sram_c_addr_o, sram_c_wdata_o (NumPE_M*NumPE_N*OutDataWidth bits) and sram_c_we_o, all outputs: C write port; PE (r,c) occupies bits [(r*NumPE_N+c)*OutDataWidth +: OutDataWidth].
REQ-015 SHALL have busy_o, done_o and err_o, outputs, 1 bit each: job active, one-cycle completion pulse, and sticky size error.

Function
REQ-016 SHALL latch tile counts Mt=M/NumPE_M, Kt=K/NumIp_K and Nt=N/NumPE_N on an accepted start.
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE, with start_i ignored outside IDLE.
REQ-018 SHALL, when any size is zero or not a multiple of its tile dimension at start, skip RUN, go to DONE, set err_o and issue no C write.
REQ-019 SHALL keep err_o set until the next accepted start, which clears it.
REQ-020 SHALL walk tiles with k innermost, then n, then m, issuing one A/B read per RUN cycle.
REQ-021 SHALL drive sram_a_addr_o = m*Kt+k and sram_b_addr_o = n*Kt+k, truncated to AddrWidth.
REQ-022 SHALL expect A/B read data exactly one cycle after the address, with stall_i extending that cycle.
REQ-023 SHALL, for each returned word, have PE (r,c) compute the signed sum over k of A(r,k)*B(c,k), writing that sum when k=0 and adding it otherwise.
REQ-024 SHALL compute products at full 2*InDataWidth precision and accumulate modulo 2^OutDataWidth.
REQ-025 SHALL, on the cycle after the k=Kt-1 data is consumed, pulse sram_c_we_o for 1 cycle with sram_c_addr_o = m*Nt+n and the full tile on sram_c_wdata_o.
REQ-026 SHALL overlap this C write with the next tile's k=0 accumulation, so results see no bubble and no corruption.
REQ-027 SHALL sustain back-to-back operation at one tile-k step per unstalled cycle.
REQ-028 SHALL enter DRAIN after the last address is issued and wait there for the final C write.
REQ-029 SHALL, in DONE, pulse done_o for 1 cycle and then return to IDLE.
REQ-030 SHALL hold busy_o high from the cycle after an accepted start through DRAIN.
REQ-031 SHALL, while stall_i is high, hold the FSM, counters, addresses, pipeline registers and accumulators, and force sram_c_we_o and done_o low.
REQ-032 SHALL present a write that was due during a stall on the first unstalled cycle.
REQ-033 SHALL not require stall_i to be low when start is accepted.

Reset
REQ-034 SHALL, with rst_ni low, immediately clear to zero the FSM (IDLE), counters, accumulators, pipeline registers and every output.
REQ-035 SHALL, on reset mid-job, abandon the job with no further C writes and no done_o.
REQ-036 SHALL leave IDLE after reset release only on a new start_i.

Verification
REQ-037 SHALL pass single tile: M=K=N=4, A=all 1, B=all 2 -> one write at C addr 0, every element 8, done_o 1 cycle later.
REQ-038 SHALL pass multi-tile: M=8, K=8, N=8, random int8 -> 4 writes at addrs 0,1,2,3 in order, matching the golden model, total RUN cycles 8.
REQ-039 SHALL pass extremes: A=-128, B=-128, K=8 -> each C element +131072, with no sign error.
REQ-040 SHALL pass stall: stall_i high 3 cycles mid-tile, M=K=N=8 -> results identical to the unstalled run, and no write while stalled.
REQ-041 SHALL pass bad size: M=6 -> err_o=1, done_o pulses within 3 cycles, zero writes; a subsequent valid start clears err_o.
REQ-042 SHALL pass reset mid-job: rst_ni low during RUN -> all outputs 0 immediately; after release no writes until start_i.
